// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
//   - state_t      : controller FSM states
//   - off_w/word_w/idx_w/tag_w : address field widths
//   - line_t       : cache line type at the default geometry
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REFILL_REQ,
    REFILL_DATA,
    RESP,
    WR_REQ,
    WR_WAIT
  } state_t;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_BLOCK_WORDS = 4;
  localparam int unsigned DEF_NUM_SETS    = 16;
  localparam int unsigned DEF_ID_W        = 8;

  typedef logic [DEF_BLOCK_WORDS-1:0][DEF_DATA_W-1:0] line_t;

  // Byte offset inside a word.
  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word offset inside a line.
  function automatic int unsigned word_w(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned data_w,
                                        input int unsigned block_words,
                                        input int unsigned num_sets);
    return addr_w - off_w(data_w) - word_w(block_words) - idx_w(num_sets);
  endfunction

endpackage

// File: rtl/dcache_dm_array.sv
// dcache_dm_array: tag/valid/data storage for the direct-mapped cache.
//   lookup_*  : combinational read port (tag, valid, whole line)
//   lw_*      : line-write port, installs a tag and sets the valid bit
//   ww_*      : strobed word-write port (refill beats and store merges)
// Only the valid bits are reset; tag and data contents are don't-care
// until their valid bit is set.
module dcache_dm_array
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
  parameter int unsigned TAG_W       = 24
) (
  input  logic                                  axi_clk,
  input  logic                                  i_rstn,
  input  logic [$clog2(NUM_SETS)-1:0]           lookup_index,
  output logic [TAG_W-1:0]                      lookup_tag,
  output logic                                  lookup_valid,
  output logic [BLOCK_WORDS-1:0][DATA_W-1:0]    lookup_line,
  input  logic                                  lw_en,
  input  logic [$clog2(NUM_SETS)-1:0]           lw_index,
  input  logic [TAG_W-1:0]                      lw_tag,
  input  logic                                  ww_en,
  input  logic [$clog2(NUM_SETS)-1:0]           ww_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0]        ww_word,
  input  logic [DATA_W-1:0]                     ww_data,
  input  logic [DATA_W/8-1:0]                   ww_strb
);

  logic [NUM_SETS-1:0]                   valid_bits;
  logic [TAG_W-1:0]                      tag_mem  [NUM_SETS];
  logic [BLOCK_WORDS-1:0][DATA_W-1:0]    data_mem [NUM_SETS];

  always_ff @(posedge axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_bits <= '0;
    end else if (lw_en) begin
      valid_bits[lw_index] <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (lw_en) begin
      tag_mem[lw_index] <= lw_tag;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (ww_en) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (ww_strb[b]) begin
          data_mem[ww_index][ww_word][b*8 +: 8] <= ww_data[b*8 +: 8];
        end
      end
    end
  end

  assign lookup_tag   = tag_mem[lookup_index];
  assign lookup_valid = valid_bits[lookup_index];
  assign lookup_line  = data_mem[lookup_index];

endmodule

// File: rtl/dcache_dm_ctrl.sv
// dcache_dm_ctrl: blocking direct-mapped data cache controller.
// Write-through, no-write-allocate; multi-word lines refilled by burst.
// Ports:
//   axi_clk, i_rstn (async, active-low)
//   rd_req/rd_ready/rd_addr/rd_id -> rd_valid/rd_data/rd_valid_id : loads
//   wr_req/wr_ready/wr_addr/wr_data/wr_strb -> wr_done             : stores
//   mem_rd_req/ack/addr, mem_rd_valid/data                         : refill burst
//   mem_wr_req/ack/addr/data/strb, mem_wr_done                     : store forward
//   stat_hits/stat_misses : load hit/miss counters
// Build option: define DCACHE_STATS_EN to build the saturating counters;
// otherwise both stat outputs are tied to zero.
module dcache_dm_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
  parameter int unsigned ID_W        = DEF_ID_W
) (
  input  logic                axi_clk,
  input  logic                i_rstn,
  input  logic                rd_req,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [ID_W-1:0]     rd_id,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ID_W-1:0]     rd_valid_id,
  input  logic                wr_req,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_done,
  output logic                mem_rd_req,
  input  logic                mem_rd_ack,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic                mem_rd_valid,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                mem_wr_req,
  input  logic                mem_wr_ack,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_strb,
  input  logic                mem_wr_done,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses
);

  localparam int unsigned OFF_W    = off_w(DATA_W);
  localparam int unsigned WORD_W   = word_w(BLOCK_WORDS);
  localparam int unsigned IDX_W    = idx_w(NUM_SETS);
  localparam int unsigned TAG_W    = tag_w(ADDR_W, DATA_W, BLOCK_WORDS, NUM_SETS);
  localparam int unsigned LINE_LSB = OFF_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BLOCK_WORDS - 1);

  state_t state, state_next;

  logic                ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [ID_W-1:0]     req_id;
  logic [WORD_W-1:0]   beat_cnt;

  logic [ADDR_W-1:0]   lookup_addr;
  logic [TAG_W-1:0]    arr_tag;
  logic                arr_valid;
  logic [BLOCK_WORDS-1:0][DATA_W-1:0] arr_line;
  logic                hit;
  logic [DATA_W-1:0]   sel_word;

  logic                rd_acc, wr_acc, refill_beat, refill_last;
  logic                ww_en;
  logic [IDX_W-1:0]    ww_index;
  logic [WORD_W-1:0]   ww_word;
  logic [DATA_W-1:0]   ww_data;
  logic [DATA_W/8-1:0] ww_strb;

  // Single lookup port: in IDLE it serves whichever request may be
  // accepted (load has priority); elsewhere it follows the pending load.
  assign lookup_addr = (state != IDLE) ? req_addr : (rd_req ? rd_addr : wr_addr);
  assign hit         = arr_valid && (arr_tag == lookup_addr[ADDR_W-1 -: TAG_W]);
  assign sel_word    = arr_line[lookup_addr[OFF_W +: WORD_W]];

  assign rd_acc      = (state == IDLE) && rd_req && ready;
  assign wr_acc      = (state == IDLE) && wr_req && ready && !rd_req;
  assign refill_beat = (state == REFILL_DATA) && mem_rd_valid;
  assign refill_last = refill_beat && (beat_cnt == LAST_BEAT);

  always_comb begin
    ww_en    = 1'b0;
    ww_index = lookup_addr[LINE_LSB +: IDX_W];
    ww_word  = lookup_addr[OFF_W +: WORD_W];
    ww_data  = wr_data;
    ww_strb  = wr_strb;
    if (refill_beat) begin
      ww_en    = 1'b1;
      ww_index = req_addr[LINE_LSB +: IDX_W];
      ww_word  = beat_cnt;
      ww_data  = mem_rd_data;
      ww_strb  = '1;
    end else if (wr_acc && hit) begin
      ww_en    = 1'b1;
    end
  end

  dcache_dm_array #(
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .NUM_SETS    (NUM_SETS),
    .TAG_W       (TAG_W)
  ) u_array (
    .axi_clk      (axi_clk),
    .i_rstn       (i_rstn),
    .lookup_index (lookup_addr[LINE_LSB +: IDX_W]),
    .lookup_tag   (arr_tag),
    .lookup_valid (arr_valid),
    .lookup_line  (arr_line),
    .lw_en        (refill_last),
    .lw_index     (req_addr[LINE_LSB +: IDX_W]),
    .lw_tag       (req_addr[ADDR_W-1 -: TAG_W]),
    .ww_en        (ww_en),
    .ww_index     (ww_index),
    .ww_word      (ww_word),
    .ww_data      (ww_data),
    .ww_strb      (ww_strb)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_acc) begin
          if (!hit) state_next = REFILL_REQ;
        end else if (wr_acc) begin
          state_next = WR_REQ;
        end
      end
      REFILL_REQ:  if (mem_rd_ack)  state_next = REFILL_DATA;
      REFILL_DATA: if (refill_last) state_next = RESP;
      RESP:        state_next = IDLE;
      WR_REQ:      if (mem_wr_ack)  state_next = WR_WAIT;
      WR_WAIT:     if (mem_wr_done) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // ready is registered from the next state so it stays low during reset
  // and rises on the first clock after reset.
  always_ff @(posedge axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      ready       <= 1'b0;
      req_addr    <= '0;
      req_id      <= '0;
      beat_cnt    <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_valid_id <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_strb <= '0;
      wr_done     <= 1'b0;
    end else begin
      state    <= state_next;
      ready    <= (state_next == IDLE);
      if (rd_acc) begin
        req_addr <= rd_addr;
        req_id   <= rd_id;
      end
      if (wr_acc) begin
        mem_wr_addr <= wr_addr;
        mem_wr_data <= wr_data;
        mem_wr_strb <= wr_strb;
      end
      if (refill_beat) begin
        beat_cnt <= beat_cnt + WORD_W'(1);
      end
      rd_valid <= (rd_acc && hit) || (state == RESP);
      if (rd_acc && hit) begin
        rd_data     <= sel_word;
        rd_valid_id <= rd_id;
      end else if (state == RESP) begin
        rd_data     <= sel_word;
        rd_valid_id <= req_id;
      end
      wr_done <= (state == WR_WAIT) && mem_wr_done;
    end
  end

  assign rd_ready    = ready;
  assign wr_ready    = ready;
  assign mem_rd_req  = (state == REFILL_REQ);
  assign mem_rd_addr = {req_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign mem_wr_req  = (state == WR_REQ);

`ifdef DCACHE_STATS_EN
  always_ff @(posedge axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (rd_acc) begin
      if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

  logic unused_byte_off;
  assign unused_byte_off = ^lookup_addr[OFF_W-1:0];

endmodule

// File: tb/tb_dcache_dm_ctrl.sv
module tb_dcache_dm_ctrl;

  logic        axi_clk = 1'b0;
  logic        i_rstn;
  logic        rd_req, rd_ready, rd_valid;
  logic [31:0] rd_addr, rd_data;
  logic [7:0]  rd_id, rd_valid_id;
  logic        wr_req, wr_ready, wr_done;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req, mem_wr_ack, mem_wr_done;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic [31:0] stat_hits, stat_misses;

  dcache_dm_ctrl #(
    .ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(4), .NUM_SETS(16), .ID_W(8)
  ) dut (
    .axi_clk(axi_clk), .i_rstn(i_rstn),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_id(rd_id),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_valid_id(rd_valid_id),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_done(wr_done),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_done(mem_wr_done),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
  } resp_t;

  int          errors = 0;
  int          checks = 0;
  resp_t       sb[$];
  logic [31:0] mem_m [logic [31:0]];
  logic        tb_vld [16];
  logic [23:0] tb_tag [16];
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'hA500_0000 | a;
  endfunction

  function automatic bit predict_hit(input logic [31:0] a);
    int unsigned idx;
    idx = (a >> 4) & 32'hF;
    return tb_vld[idx] && (tb_tag[idx] == a[31:8]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      tb_vld[i] = 1'b0;
      tb_tag[i] = '0;
    end
    sb.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_req(input logic [31:0] a, input logic [7:0] id);
    int          n;
    int unsigned idx;
    bit          h;
    h   = predict_hit(a);
    idx = (a >> 4) & 32'hF;
    rd_req = 1'b1; rd_addr = a; rd_id = id;
    n = 0;
    while (!rd_ready && n < 20) begin @(negedge axi_clk); n++; end
    chk("rd_ready_wait", 64'(rd_ready), 64'd1);
    @(negedge axi_clk);
    rd_req = 1'b0;
    sb.push_back('{mem_word(a & ~32'h3), id});
    if (h) exp_hits++;
    else begin
      exp_misses++;
      tb_vld[idx] = 1'b1;
      tb_tag[idx] = a[31:8];
    end
  endtask

  task automatic serve_refill(input logic [31:0] a, input int nbeats, input int gap, input bit extra);
    int          n;
    logic [31:0] line;
    line = a & ~32'hF;
    n = 0;
    while (!mem_rd_req && n < 20) begin @(negedge axi_clk); n++; end
    chk("mem_rd_req_wait", 64'(mem_rd_req), 64'd1);
    chk("mem_rd_addr", 64'(mem_rd_addr), 64'(line));
    mem_rd_ack = 1'b1;
    @(negedge axi_clk);
    mem_rd_ack = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0) repeat (gap) @(negedge axi_clk);
      mem_rd_valid = 1'b1;
      mem_rd_data  = mem_word(line + 32'(4 * k));
      @(negedge axi_clk);
      mem_rd_valid = 1'b0;
    end
    if (extra) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hBAD0_BAD0;
      @(negedge axi_clk);
      mem_rd_valid = 1'b0;
    end
  endtask

  // Leaves the bench on the negedge where rd_valid is observed high.
  task automatic wait_resp(input string tag, input int bound);
    int    n;
    resp_t e;
    n = 0;
    while (!rd_valid && n < bound) begin @(negedge axi_clk); n++; end
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, 64'(rd_data), 64'(e.data));
      chk({tag, "_id"}, 64'(rd_valid_id), 64'(e.id));
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [7:0] id,
                         input int gap, input bit ack_early, input bit extra);
    bit h;
    h = predict_hit(a);
    if (!h && ack_early) mem_rd_ack = 1'b1;
    load_req(a, id);
    if (h) begin
      chk({tag, "_no_refill"}, 64'(mem_rd_req), 64'd0);
      wait_resp(tag, 0);
    end else begin
      serve_refill(a, 4, gap, extra);
      wait_resp(tag, 10);
    end
    @(negedge axi_clk);
    chk({tag, "_pulse"}, 64'(rd_valid), 64'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit ack_early);
    int          n;
    logic [31:0] old, merged;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    if (ack_early) mem_wr_ack = 1'b1;
    n = 0;
    while (!wr_ready && n < 20) begin @(negedge axi_clk); n++; end
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    @(negedge axi_clk);
    wr_req = 1'b0;
    old = mem_word(a & ~32'h3);
    for (int b = 0; b < 4; b++) merged[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    mem_m[a & ~32'h3] = merged;
    n = 0;
    while (!mem_wr_req && n < 20) begin @(negedge axi_clk); n++; end
    chk({tag, "_mem_wr_req"}, 64'(mem_wr_req), 64'd1);
    chk({tag, "_mem_wr_addr"}, 64'(mem_wr_addr), 64'(a));
    chk({tag, "_mem_wr_data"}, 64'(mem_wr_data), 64'(d));
    chk({tag, "_mem_wr_strb"}, 64'(mem_wr_strb), 64'(s));
    mem_wr_ack = 1'b1;
    @(negedge axi_clk);
    mem_wr_ack = 1'b0;
    repeat (2) @(negedge axi_clk);
    chk({tag, "_done_early"}, 64'(wr_done), 64'd0);
    mem_wr_done = 1'b1;
    @(negedge axi_clk);
    mem_wr_done = 1'b0;
    chk({tag, "_wr_done"}, 64'(wr_done), 64'd1);
    @(negedge axi_clk);
    chk({tag, "_done_pulse"}, 64'(wr_done), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'(|{rd_ready, rd_valid, rd_data, rd_valid_id, wr_ready, wr_done,
                 mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
                 mem_wr_strb, stat_hits, stat_misses});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_id = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    mem_wr_ack = 1'b0; mem_wr_done = 1'b0;
    clear_model();

    // Reset state
    repeat (3) @(negedge axi_clk);
    chk("reset_outputs", all_outs(), 64'd0);
    i_rstn = 1'b1;
    @(negedge axi_clk);
    chk("ready_after_reset", 64'({rd_ready, wr_ready}), 64'b11);

    // Cold miss with an extra beat after the burst, then hits in the line
    do_load("ld100_miss", 32'h100, 8'h11, 0, 1'b0, 1'b1);
    do_load("ld104_hit",  32'h104, 8'h12, 0, 1'b0, 1'b0);
    do_load("ld100_hit",  32'h100, 8'h13, 0, 1'b0, 1'b0);

    // Conflict miss with early ack and gapped beats, then eviction reload
    do_load("ld500_miss", 32'h500, 8'h21, 2, 1'b1, 1'b0);
    do_load("ld100_evict", 32'h100, 8'h22, 1, 1'b0, 1'b0);

    // Store hit with byte merge, then reload hits with merged word
    do_store("st108", 32'h108, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    do_load("ld108_merged", 32'h108, 8'h31, 0, 1'b0, 1'b0);

    // Stray beat and stray done in IDLE are ignored
    mem_rd_valid = 1'b1; mem_rd_data = 32'h5A5A_5A5A; mem_wr_done = 1'b1;
    @(negedge axi_clk);
    mem_rd_valid = 1'b0; mem_wr_done = 1'b0;
    chk("stray_done", 64'(wr_done), 64'd0);
    do_load("ld10c_hit", 32'h10C, 8'h32, 0, 1'b0, 1'b0);

    // Simultaneous load and store: load first, store waits
    wr_req = 1'b1; wr_addr = 32'h30C; wr_data = 32'h1234_5678; wr_strb = 4'b1100;
    load_req(32'h110, 8'h41);
    chk("simul_wr_blocked", 64'(wr_ready), 64'd0);
    serve_refill(32'h110, 4, 0, 1'b0);
    chk("simul_wr_still_blocked", 64'({wr_ready, mem_wr_req}), 64'd0);
    wait_resp("ld110_simul", 10);
    chk("simul_wr_ready_now", 64'(wr_ready), 64'd1);
    do_store("st30c_miss", 32'h30C, 32'h1234_5678, 4'b1100, 1'b1);
    do_load("ld30c_miss", 32'h30C, 8'h42, 0, 1'b0, 1'b0);

    // Reset during a burst after two beats
    load_req(32'h200, 8'h51);
    serve_refill(32'h200, 2, 0, 1'b0);
    i_rstn = 1'b0;
    #1;
    chk("midburst_reset_outputs", all_outs(), 64'd0);
    clear_model();
    @(negedge axi_clk);
    i_rstn = 1'b1;
    repeat (3) @(negedge axi_clk);
    chk("no_resp_after_reset", 64'({rd_valid, wr_done, mem_rd_req}), 64'd0);

    // Same address misses again; statistics on 3 hits and 2 misses
    do_load("ld200_after_rst", 32'h200, 8'h61, 0, 1'b0, 1'b0);
    do_load("ld204_hit", 32'h204, 8'h62, 0, 1'b0, 1'b0);
    do_load("ld208_hit", 32'h208, 8'h63, 0, 1'b0, 1'b0);
    do_load("ld20c_hit", 32'h20C, 8'h64, 0, 1'b0, 1'b0);
    do_load("ld600_miss", 32'h600, 8'h65, 0, 1'b0, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'(exp_hits));
    chk("stat_misses", 64'(stat_misses), 64'(exp_misses));
`else
    chk("stat_hits_off", 64'(stat_hits), 64'd0);
    chk("stat_misses_off", 64'(stat_misses), 64'd0);
`endif
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
